// File: rtl/mem_responder.sv
// Word-addressed memory slave: accepts a level-held read/write, completes with a one-cycle Ready after WAIT_CYC+1 cycles.
// Backpressure: the initiator holds Memread/Memwrite until Ready; dropping the request during WAIT aborts it.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYC    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Memread,
  input  logic        Memwrite,
  input  logic [31:0] Addr,
  inout  wire  [31:0] BUS,
  output logic        Ready,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic          oor_q, oor_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   acc_off, acc_idx;
  logic          acc_oor, req_live, commit, bus_oe;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign acc_off  = Addr - BASE_ADDR;
  assign acc_idx  = acc_off >> 2;
  assign acc_oor  = acc_idx >= DEPTH_WORDS;
  assign req_live = is_wr_q ? Memwrite : Memread;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (Memread || Memwrite) begin
          is_wr_d = Memwrite;
          idx_d   = acc_idx[AW-1:0];
          oor_d   = acc_oor;
          err_d   = err_q | acc_oor;
          cnt_d   = 3'(WAIT_CYC);
          if (Memwrite) begin
            wdata_d = BUS;
          end else begin
            rdata_d = acc_oor ? 32'h0 : mem[acc_idx[AW-1:0]];
          end
          state_d = (WAIT_CYC == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!req_live) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit on the edge entering DONE; rst gates the zero-wait path that leaves IDLE directly.
  assign commit = rst && (state_d == DONE) && (state_q != DONE) && is_wr_d && !oor_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      is_wr_q <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[idx_d] <= wdata_d;
  end

  // Live Memwrite term keeps the bus released the moment the initiator starts driving.
  assign bus_oe = !is_wr_q && (state_q != IDLE) && !Memwrite;
  assign BUS    = bus_oe ? rdata_q : 32'hzzzz_zzzz;
  assign Ready  = (state_q == DONE);
  assign Err    = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal array, power of two, 16..4096.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0, aligned to DEPTH_WORDS*4.
REQ-003 Parameter WAIT_CYC, default 1: extra cycles between request acceptance and completion, range 0..7.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 Memread  input  1  read request from the initiator, level-held until Ready.
REQ-007 Memwrite  input  1  write request from the initiator, level-held until Ready; the initiator drives BUS while high.
REQ-008 Addr  input  32  byte address; Addr[1:0] is ignored.
REQ-009 BUS  inout  32  shared data bus; driven by this block only as defined in REQ-019, high-Z otherwise.
REQ-010 Ready  output  1  one-cycle pulse marking completion of the current request.
REQ-011 Err  output  1  sticky flag: an access targeted an address outside the array.

Function
REQ-012 State machine SHALL have states IDLE, WAIT, DONE; reset state is IDLE.
REQ-013 In IDLE, a rising edge with Memwrite=1 SHALL accept a write: latch word index = (Addr-BASE_ADDR)>>2 and latch BUS into wdata.
REQ-014 In IDLE, a rising edge with Memread=1 and Memwrite=0 SHALL accept a read: latch the word index and load rdata from the array (0 if out of range).
REQ-015 If Memread and Memwrite are both 1 at acceptance, the request SHALL be treated as a write, and BUS SHALL never be driven for it.
REQ-016 After acceptance, the block SHALL go to WAIT with counter = WAIT_CYC; if WAIT_CYC=0 it SHALL go directly to DONE.
REQ-017 In WAIT, the counter SHALL decrement once per cycle, and the block SHALL move to DONE on the edge where counter = 1.
REQ-018 In DONE, Ready SHALL be 1 for exactly one cycle; a write SHALL commit wdata to the array on entry to DONE; the next state SHALL be IDLE.
REQ-019 BUS SHALL be driven with rdata only while a read is in WAIT or DONE and Memwrite=0; the drive enable SHALL be combinational on Memwrite so that no contention is possible.
REQ-020 A request whose signal is still high in the IDLE cycle after DONE SHALL be accepted as a new request (back-to-back at one IDLE cycle per access).
REQ-021 If the request signal drops during WAIT (abort), the block SHALL return to IDLE on the next edge, pulse no Ready, and perform no array write.
REQ-022 Out-of-range access (Addr < BASE_ADDR or index >= DEPTH_WORDS) SHALL set Err, return 32'h0 on a read, discard a write, and still complete with Ready.
REQ-023 Err SHALL clear only on reset.
REQ-024 Index arithmetic SHALL be 32-bit unsigned; Addr below BASE_ADDR wraps to a large index and is therefore out of range.
REQ-025 The array SHALL have no reset; its contents after power-up are undefined in simulation except where preloaded.

Reset
REQ-026 On rst=0, asynchronously: state=IDLE, counter=0, Ready=0, Err=0, BUS drive disabled, rdata=0, wdata=0.
REQ-027 Reset asserted mid-request SHALL abort the request with no array write; the first acceptance after rst returns to 1 occurs on the first rising edge at which a request is present.

Verification
REQ-028 Test 1: WAIT_CYC=1, write 32'hDEADBEEF to 0x10, then read 0x10 -> Ready pulses 2 cycles after each acceptance; BUS=32'hDEADBEEF during the read DONE.
REQ-029 Test 2: read 0x13 after writing 0x10 -> same data is returned, because the low address bits are ignored.
REQ-030 Test 3: Memread=1 and Memwrite=1 together with Addr=0x20 and BUS=32'h1234 -> write occurs, the block never drives BUS, and a later read of 0x20 returns 32'h1234.
REQ-031 Test 4: read at Addr=DEPTH_WORDS*4 -> returns 32'h0, Err=1 and stays 1 until reset, Ready still pulses.
REQ-032 Test 5: WAIT_CYC=3, drop Memwrite in the second WAIT cycle -> no Ready, array unchanged, state=IDLE.
REQ-033 Test 6: rst=0 during the WAIT of a write to 0x40 -> Ready=0, BUS=Z immediately, and a read of 0x40 after reset returns its prior value.
